// File: rtl/slsu_if.sv
// Execute-stage request/response and data-memory port bundle for slsu.
// slave = the load/store unit; master = the requester together with the memory.
interface slsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [2:0]            req_funct3_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  resp_valid_o;
    logic [DATA_WIDTH-1:0] resp_rdata_o;
    logic                  resp_fault_o;
    logic                  busy_o;
    logic                  mem_read_o;
    logic                  mem_write_o;
    logic [1:0]            mem_size_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o, busy_o,
        output mem_read_o, mem_write_o, mem_size_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o, busy_o,
        input  mem_read_o, mem_write_o, mem_size_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/slsu.sv
// slsu: one-at-a-time load/store unit driving a byte-addressed data memory.
// Optional macro MISALIGNED_SPLIT_EN: misaligned H/W performed as sequential byte accesses.
module slsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 1024
) (
    input logic   clk,
    input logic   rst_n,
    slsu_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH+1)'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
`ifdef MISALIGNED_SPLIT_EN
        SPLIT  = 2'd3,
`endif
        RESP   = 2'd2
    } state_t;

    state_t                state;
    logic                  ready_q;
    logic                  busy_q;
    logic                  resp_valid_q;
    logic                  resp_fault_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [1:0]            mem_size_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic                  we_q;
    logic [2:0]            funct3_q;

    logic                  illegal;
    logic                  misaligned;
    logic                  out_of_bounds;
    logic                  fault;
    logic [ADDR_WIDTH:0]   addr_ext;
    logic [ADDR_WIDTH:0]   span;

`ifdef MISALIGNED_SPLIT_EN
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] asm_full;
    logic [1:0]            cnt_q;
    logic [1:0]            cnt_next;
    logic [1:0]            last_idx;

    assign cnt_next = cnt_q + 2'd1;
    assign last_idx = funct3_q[1] ? 2'd3 : 2'd1;

    // The byte arriving this cycle is merged so RESP can extend without an extra cycle.
    always_comb begin
        asm_full = asm_q;
        asm_full[{cnt_q, 3'b000} +: 8] = bus.mem_rdata_i[7:0];
    end
`endif

    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [2:0] funct3,
                                                          input logic [DATA_WIDTH-1:0] data);
        logic [DATA_WIDTH-1:0] result;
        case (funct3)
            3'b000:  result = {{(DATA_WIDTH-8){data[7]}}, data[7:0]};
            3'b100:  result = {{(DATA_WIDTH-8){1'b0}}, data[7:0]};
            3'b001:  result = {{(DATA_WIDTH-16){data[15]}}, data[15:0]};
            3'b101:  result = {{(DATA_WIDTH-16){1'b0}}, data[15:0]};
            default: result = data;
        endcase
        return result;
    endfunction

    // Classification is evaluated in ADDR_WIDTH+1 bits so the end-address sum cannot wrap.
    always_comb begin
        illegal       = 1'b0;
        misaligned    = 1'b0;
        out_of_bounds = 1'b0;
        fault         = 1'b0;
        addr_ext      = {1'b0, bus.req_addr_i};
        span          = '0;
        if (bus.req_we_i) illegal = (bus.req_funct3_i > 3'b010);
        else              illegal = (bus.req_funct3_i == 3'b011) || (bus.req_funct3_i[2:1] == 2'b11);
        case (bus.req_funct3_i[1:0])
            2'b01: begin
                span       = (ADDR_WIDTH+1)'(1);
                misaligned = bus.req_addr_i[0];
            end
            2'b10: begin
                span       = (ADDR_WIDTH+1)'(3);
                misaligned = (bus.req_addr_i[1:0] != 2'b00);
            end
            default: span = '0;
        endcase
        out_of_bounds = misaligned ? ((addr_ext + span) > LAST_WORD) : (addr_ext > LAST_WORD);
`ifdef MISALIGNED_SPLIT_EN
        fault = illegal | out_of_bounds;
`else
        fault = illegal | misaligned | out_of_bounds;
`endif
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req_valid_i) begin
            we_q     <= bus.req_we_i;
            funct3_q <= bus.req_funct3_i;
`ifdef MISALIGNED_SPLIT_EN
            addr_q   <= bus.req_addr_i;
            wdata_q  <= bus.req_wdata_i;
            asm_q    <= '0;
`endif
        end
`ifdef MISALIGNED_SPLIT_EN
        else if (state == SPLIT) begin
            asm_q <= asm_full;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_size_q   <= 2'b00;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef MISALIGNED_SPLIT_EN
            cnt_q        <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (fault) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_rdata_q <= '0;
                        end
`ifdef MISALIGNED_SPLIT_EN
                        else if (misaligned) begin
                            state       <= SPLIT;
                            cnt_q       <= 2'd0;
                            mem_read_q  <= !bus.req_we_i;
                            mem_write_q <= bus.req_we_i;
                            mem_size_q  <= 2'b00;
                            mem_addr_q  <= bus.req_addr_i;
                            mem_wdata_q <= bus.req_we_i ?
                                           {{(DATA_WIDTH-8){1'b0}}, bus.req_wdata_i[7:0]} : '0;
                        end
`endif
                        else begin
                            state       <= ACCESS;
                            mem_read_q  <= !bus.req_we_i;
                            mem_write_q <= bus.req_we_i;
                            mem_size_q  <= bus.req_funct3_i[1:0];
                            mem_addr_q  <= bus.req_addr_i;
                            mem_wdata_q <= bus.req_we_i ? bus.req_wdata_i : '0;
                        end
                    end
                end
                ACCESS: begin
                    state        <= RESP;
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                    mem_size_q   <= 2'b00;
                    mem_addr_q   <= '0;
                    mem_wdata_q  <= '0;
                    resp_valid_q <= 1'b1;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= we_q ? '0 : extend_load(funct3_q, bus.mem_rdata_i);
                end
`ifdef MISALIGNED_SPLIT_EN
                SPLIT: begin
                    if (cnt_q == last_idx) begin
                        state        <= RESP;
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                        mem_size_q   <= 2'b00;
                        mem_addr_q   <= '0;
                        mem_wdata_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b0;
                        resp_rdata_q <= we_q ? '0 : extend_load(funct3_q, asm_full);
                    end else begin
                        cnt_q       <= cnt_next;
                        mem_addr_q  <= addr_q + ADDR_WIDTH'(cnt_next);
                        mem_wdata_q <= we_q ?
                                       {{(DATA_WIDTH-8){1'b0}}, wdata_q[{cnt_next, 3'b000} +: 8]} : '0;
                    end
                end
`endif
                RESP: begin
                    state        <= IDLE;
                    ready_q      <= 1'b1;
                    busy_q       <= 1'b0;
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: begin
                    state        <= IDLE;
                    ready_q      <= 1'b1;
                    busy_q       <= 1'b0;
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= '0;
                    mem_read_q   <= 1'b0;
                    mem_write_q  <= 1'b0;
                    mem_size_q   <= 2'b00;
                    mem_addr_q   <= '0;
                    mem_wdata_q  <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready_o  = ready_q;
    assign bus.busy_o       = busy_q;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_fault_o = resp_fault_q;
    assign bus.resp_rdata_o = resp_rdata_q;
    assign bus.mem_read_o   = mem_read_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_size_o   = mem_size_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wdata_o  = mem_wdata_q;
endmodule

// File: tb/tb_slsu.sv
// Bench for slsu: byte-array memory model, vector table with a response scoreboard,
// plus hand sequences for split accesses and reset in the middle of a store.
module tb_slsu;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MB = 1024;
`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT_ON = 1'b1;
`else
    localparam bit SPLIT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;

    slsu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    slsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_BYTES(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        int          strobes;
    } vec_t;
    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
    } wr_t;

    exp_t sb[$];
    wr_t  wlog[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Memory model: sign-extends B/H reads like the real data memory.
    logic [7:0] mem [0:MB-1];
    logic [9:0] wa0, wa1, wa2, wa3;
    logic [7:0] b0, b1, b2, b3;
    assign wa0 = bus.mem_addr_o[9:0];
    assign wa1 = wa0 + 10'd1;
    assign wa2 = wa0 + 10'd2;
    assign wa3 = wa0 + 10'd3;
    assign b0 = mem[wa0];
    assign b1 = mem[wa1];
    assign b2 = mem[wa2];
    assign b3 = mem[wa3];

    always_comb begin
        bus.mem_rdata_i = {b3, b2, b1, b0};
        if (bus.mem_size_o == 2'b00)      bus.mem_rdata_i = {{24{b0[7]}}, b0};
        else if (bus.mem_size_o == 2'b01) bus.mem_rdata_i = {{16{b1[7]}}, b1, b0};
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_clr) begin
            for (int i = 0; i < MB; i++) mem[i] <= 8'h00;
        end else if (bus.mem_write_o) begin
            mem[wa0] <= bus.mem_wdata_o[7:0];
            if (bus.mem_size_o != 2'b00) mem[wa1] <= bus.mem_wdata_o[15:8];
            if (bus.mem_size_o == 2'b10) begin
                mem[wa2] <= bus.mem_wdata_o[23:16];
                mem[wa3] <= bus.mem_wdata_o[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic flt, input logic [31:0] rd,
                                input int lat, input int st);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.fault = flt; v.rdata = rd; v.lat = lat; v.strobes = st;
        return v;
    endfunction

    task automatic do_req(input vec_t v, input string tag);
        int   guard;
        int   strobes;
        bit   done;
        exp_t e;
        wr_t  w;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready_o && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, ".ready"}, {31'd0, bus.req_ready_o}, 32'd1);
        if (!bus.req_ready_o) return;
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = v.we;
        bus.req_funct3_i = v.f3;
        bus.req_addr_i   = v.addr;
        bus.req_wdata_i  = v.wdata;
        wlog.delete();
        strobes = 0;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        e.fault = v.fault; e.rdata = v.rdata; e.lat = v.lat; e.acc = cyc;
        sb.push_back(e);
        done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            if (n == 0) chk({tag, ".busy"}, {31'd0, bus.busy_o}, 32'd1);
            if (bus.mem_write_o || bus.mem_read_o) strobes++;
            if (bus.mem_write_o) begin
                w.addr = bus.mem_addr_o; w.size = bus.mem_size_o; w.data = bus.mem_wdata_o;
                wlog.push_back(w);
            end
            if (bus.resp_valid_o && sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, ".rdata"}, bus.resp_rdata_o, e.rdata);
                chk({tag, ".fault"}, {31'd0, bus.resp_fault_o}, {31'd0, e.fault});
                chk({tag, ".latency"}, cyc - e.acc + 1, e.lat);
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: no resp_valid_o within 30 cycles, required one", tag);
            sb.delete();
        end else begin
            @(negedge clk);
            chk({tag, ".pulse"}, {31'd0, bus.resp_valid_o}, 32'd0);
            chk({tag, ".idle"}, {30'd0, bus.req_ready_o, bus.busy_o}, 32'd2);
        end
        chk({tag, ".strobes"}, strobes, v.strobes);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = 3'b000;
        bus.req_addr_i   = '0;
        bus.req_wdata_i  = '0;

        repeat (3) @(negedge clk);
        chk("rst.ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("rst.busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst.resp", {30'd0, bus.resp_valid_o, bus.resp_fault_o}, 32'd0);
        chk("rst.rdata", bus.resp_rdata_o, 32'd0);
        chk("rst.strobes", {28'd0, bus.mem_read_o, bus.mem_write_o, bus.mem_size_o}, 32'd0);
        chk("rst.addr", bus.mem_addr_o, 32'd0);
        chk("rst.wdata", bus.mem_wdata_o, 32'd0);
        mem_clr = 1'b0;
        rst_n = 1'b1;

        // Aligned word store: one write strobe of size 10.
        do_req(mk(1, 3'b010, 32'h10, 32'h12345678, 0, 32'h0, 2, 1), "sw10");
        chk("sw10.wlog_n", wlog.size(), 1);
        if (wlog.size() == 1) begin
            chk("sw10.addr", wlog[0].addr, 32'h10);
            chk("sw10.size", {30'd0, wlog[0].size}, 32'd2);
            chk("sw10.data", wlog[0].data, 32'h12345678);
        end

        tbl.push_back(mk(0, 3'b010, 32'h10,  32'h0,        0, 32'h12345678, 2, 1));
        tbl.push_back(mk(1, 3'b000, 32'h21,  32'hABCDEF80, 0, 32'h0,        2, 1));
        tbl.push_back(mk(0, 3'b000, 32'h21,  32'h0,        0, 32'hFFFFFF80, 2, 1));
        tbl.push_back(mk(0, 3'b100, 32'h21,  32'h0,        0, 32'h00000080, 2, 1));
        tbl.push_back(mk(1, 3'b001, 32'h22,  32'h55558001, 0, 32'h0,        2, 1));
        tbl.push_back(mk(0, 3'b101, 32'h22,  32'h0,        0, 32'h00008001, 2, 1));
        tbl.push_back(mk(0, 3'b001, 32'h22,  32'h0,        0, 32'hFFFF8001, 2, 1));
        tbl.push_back(mk(0, 3'b010, 32'h20,  32'h0,        0, 32'h80018000, 2, 1));
        tbl.push_back(mk(1, 3'b010, 32'h3FC, 32'hCAFEF00D, 0, 32'h0,        2, 1));
        tbl.push_back(mk(0, 3'b010, 32'h3FC, 32'h0,        0, 32'hCAFEF00D, 2, 1));
        tbl.push_back(mk(0, 3'b010, 32'h3FD, 32'h0,        1, 32'h0,        1, 0));
        tbl.push_back(mk(0, 3'b000, 32'h3FE, 32'h0,        1, 32'h0,        1, 0));
        tbl.push_back(mk(0, 3'b011, 32'h10,  32'h0,        1, 32'h0,        1, 0));
        tbl.push_back(mk(0, 3'b110, 32'h10,  32'h0,        1, 32'h0,        1, 0));
        tbl.push_back(mk(1, 3'b100, 32'h10,  32'hFFFFFFFF, 1, 32'h0,        1, 0));
        tbl.push_back(mk(0, 3'b001, 32'h13,  32'h0, !SPLIT_ON,
                         SPLIT_ON ? 32'h00000012 : 32'h0, SPLIT_ON ? 3 : 1, SPLIT_ON ? 2 : 0));
        for (int i = 0; i < tbl.size(); i++) do_req(tbl[i], $sformatf("vec%0d", i));

        // Misaligned word store/load and a half load straddling its bytes.
        do_req(mk(1, 3'b010, 32'h31, 32'hA1B2C3D4, !SPLIT_ON, 32'h0,
                  SPLIT_ON ? 5 : 1, SPLIT_ON ? 4 : 0), "sw31");
`ifdef MISALIGNED_SPLIT_EN
        chk("sw31.wlog_n", wlog.size(), 4);
        if (wlog.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("sw31.addr%0d", k), wlog[k].addr, 32'h31 + k);
                chk($sformatf("sw31.size%0d", k), {30'd0, wlog[k].size}, 32'd0);
            end
            chk("sw31.data0", wlog[0].data, 32'hD4);
            chk("sw31.data1", wlog[1].data, 32'hC3);
            chk("sw31.data2", wlog[2].data, 32'hB2);
            chk("sw31.data3", wlog[3].data, 32'hA1);
        end
`endif
        do_req(mk(0, 3'b010, 32'h31, 32'h0, !SPLIT_ON, SPLIT_ON ? 32'hA1B2C3D4 : 32'h0,
                  SPLIT_ON ? 5 : 1, SPLIT_ON ? 4 : 0), "lw31");
        do_req(mk(0, 3'b001, 32'h33, 32'h0, !SPLIT_ON, SPLIT_ON ? 32'hFFFFA1B2 : 32'h0,
                  SPLIT_ON ? 3 : 1, SPLIT_ON ? 2 : 0), "lh33");

        // Reset asserted while a word store is in ACCESS.
        @(negedge clk);
        chk("rmid.ready", {31'd0, bus.req_ready_o}, 32'd1);
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = 1'b1;
        bus.req_funct3_i = 3'b010;
        bus.req_addr_i   = 32'h40;
        bus.req_wdata_i  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        chk("rmid.write_on", {31'd0, bus.mem_write_o}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rmid.write_off", {31'd0, bus.mem_write_o}, 32'd0);
        chk("rmid.ready_rst", {31'd0, bus.req_ready_o}, 32'd1);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk($sformatf("rmid.noresp%0d", n), {31'd0, bus.resp_valid_o}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rmid.noresp_post", {31'd0, bus.resp_valid_o}, 32'd0);
        chk("rmid.ready_post", {31'd0, bus.req_ready_o}, 32'd1);
        do_req(mk(0, 3'b010, 32'h10, 32'h0, 0, 32'h12345678, 2, 1), "lw10_post");
        do_req(mk(0, 3'b010, 32'h40, 32'h0, 0, 32'h00000000, 2, 1), "lw40_post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/slsu.md
# slsu

Load/store unit for the scalar core: the initiator side of the data-memory port. It accepts one load or store at a time from the execute stage over a valid/ready handshake. It decodes the RISC-V funct3 width and signedness, checks alignment and bounds, drives the byte-addressed data memory's read/write/size/address/data strobes, and returns the extended load data or a fault as a one-cycle response pulse.

## Interface
- DATA_WIDTH, 32, data path width (fixed at 32).
- ADDR_WIDTH, 32, address width.
- MEM_BYTES, 1024, data memory size in bytes; must match the memory instance.
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit idle, request accepted when valid&ready.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  store data (low bytes used for B/H).
- resp_valid_o  out  1  one-cycle completion pulse (loads and stores).
- resp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores/faults.
- resp_fault_o  out  1  misaligned, out-of-bounds or illegal funct3; valid with resp_valid_o.
- busy_o  out  1  request in flight (state != IDLE).
- mem_read_o  out  1  memory read enable.
- mem_write_o  out  1  memory write enable.
- mem_size_o  out  2  00 byte, 01 half, 10 word.
- mem_addr_o  out  ADDR_WIDTH  memory byte address.
- mem_wdata_o  out  DATA_WIDTH  memory write data, little-endian (byte 0 = bits 7:0).
- mem_rdata_i  in  DATA_WIDTH  memory read data. Combinational from memory; the memory sign-extends B/H.

## Operation
- States: IDLE, ACCESS, SPLIT, RESP. req_ready_o = (state==IDLE).
- On accept: latch we, funct3, addr and wdata into request registers. Classify, in priority order:
  - Illegal: load funct3 in {011,110,111}, or store funct3 > 010.
  - Misaligned: H with addr[0]!=0, or W with addr[1:0]!=0.
  - Out-of-bounds: aligned access with addr > MEM_BYTES-4, or split access with addr+nbytes-1 > MEM_BYTES-4. Computed in ADDR_WIDTH+1 bits, so there is no wrap.
- Transitions:
  - Illegal, out-of-bounds, or misaligned without split support: IDLE -> RESP with fault=1. No memory strobe is ever asserted.
  - Aligned: IDLE -> ACCESS -> RESP.
  - Misaligned with split: IDLE -> SPLIT; count k = 0..nbytes-1; -> RESP.
  - RESP always -> IDLE.
- All mem_* outputs are registered; there is no combinational path from req_* to mem_*. Outside ACCESS/SPLIT: read/write = 0, size/addr/wdata = 0.
- ACCESS:
  - mem_size_o = funct3[1:0] and mem_addr_o = addr.
  - Store: mem_wdata_o = wdata.
  - Load: capture mem_rdata_i at the end of the cycle.
- Load extension ignores the memory's upper bits:
  - B: sign-extend rdata[7:0]; BU: zero-extend rdata[7:0].
  - H: sign-extend rdata[15:0]; HU: zero-extend rdata[15:0].
  - W: rdata unchanged.
- Reset values: every output 0, except req_ready_o = 1. State = IDLE.
- Reset mid-operation: all strobes drop immediately and the request is dropped with no resp_valid_o. A split store may be left partially written; this is accepted behaviour.

## Timing
- Accept at edge E0.
- Aligned access: strobes are high for the single cycle E0–E1, the memory write or read capture happens at E1, and resp_valid_o is high E1–E2. req_ready_o returns at E2. Throughput is 1 request per 3 cycles.
- Fault: resp_valid_o is high E0–E1 and req_ready_o returns at E1.
- Split access: nbytes strobe cycles (2 for H, 4 for W), then one RESP cycle.
- resp_valid_o is never held longer than 1 cycle. There is no response back-pressure.
- req_valid_i while busy is ignored; the requester holds the request until it is accepted.

## Configuration
- MISALIGNED_SPLIT_EN defined: misaligned H/W is performed as sequential byte accesses.
  - Each step k uses mem_size_o = 00 and mem_addr_o = addr+k.
  - Stores drive wdata byte k on mem_wdata_o[7:0], with the upper bits 0.
  - Loads place mem_rdata_i[7:0] into byte lane k of an assembly register. Extension is applied in RESP.
- MISALIGNED_SPLIT_EN undefined: misaligned H/W faults with no memory access, and the SPLIT state and byte counter are not built.

## Test plan
- SW 0x12345678 @0x10, then LW @0x10 -> mem_write_o for 1 cycle with size 10; the load returns resp_rdata_o = 0x12345678 two cycles after accept, fault = 0.
- SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080. SH 0x8001 @0x22 then LHU @0x22 -> 0x00008001.
- Macro off: LH @0x13 -> resp_fault_o = 1 and rdata 0 one cycle after accept; mem_read_o and mem_write_o never asserted. Load funct3 = 011 -> same result.
- Macro on: SW 0xA1B2C3D4 @0x31 -> byte writes D4, C3, B2, A1 at 0x31–0x34 on consecutive cycles. LW @0x31 -> 0xA1B2C3D4 with resp 5 cycles after accept.
- MEM_BYTES = 1024: LW @0x3FC -> no fault; LW @0x3FD or LB @0x3FE -> fault with no strobe.
- Assert rst_n low during ACCESS of a SW -> mem_write_o = 0 immediately and no resp_valid_o; after release req_ready_o = 1 and a following LW completes normally.
